rr_trace_packer: RTL and testbench

//  Record-side densifier for the storage backend: accepts variable-length logging units
//  (rr_stream_bus_t data/len) and packs them LSB-first, gap-free, into fixed OUT_WIDTH words
//  for the AXI write path. Adds start/finish session control, a zero-padded flush with an
//  out_last marker, and bit/word counters for CSR readback. Sits between the record

---
 rtl/rr_trace_packer.sv | 114 +++++++++++
 tb/tb_rr_trace_packer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_trace_packer.sv
// Packs variable-length logging units LSB-first and gap-free into fixed OUT_WIDTH words,
// with start/finish session control, zero-padded flush and CSR bit/word counters.
//
// state   | meaning
// S_IDLE  | after reset, no session
// S_RUN   | accepting units, emitting full words
// S_FLUSH | no intake, draining full words then the zero-padded residue
// S_DONE  | session drained, counters held until next start
module rr_trace_packer #(
  parameter int IN_WIDTH   = 600,
  parameter int OUT_WIDTH  = 512,
  parameter int LEN_WIDTH  = $clog2(IN_WIDTH + 1),
  parameter int FILL_WIDTH = $clog2(OUT_WIDTH + IN_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  finish,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic [LEN_WIDTH-1:0]  in_len,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [63:0]           bits_in,
  output logic [31:0]           words_out
);

  localparam int BUF_WIDTH = OUT_WIDTH + IN_WIDTH - 1;
  localparam logic [FILL_WIDTH-1:0] OUT_W_F = FILL_WIDTH'(OUT_WIDTH);
  localparam logic [LEN_WIDTH-1:0]  IN_W_L  = LEN_WIDTH'(IN_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                 state, state_nxt;
  logic [BUF_WIDTH-1:0]   buf_q, buf_nxt, buf_base, buf_ins;
  logic [FILL_WIDTH-1:0]  fill, fill_nxt, fill_base;
  logic [63:0]            bits_nxt;
  logic [31:0]            words_nxt;
  logic                   out_fire, in_fire, sess_clear;
  logic [LEN_WIDTH-1:0]   len_eff;
  logic [IN_WIDTH-1:0]    in_masked;

  // Oversized lengths are illegal; clamp so the buffer invariant still holds.
  assign len_eff   = (in_len > IN_W_L) ? IN_W_L : in_len;
  assign in_masked = in_data & ({IN_WIDTH{1'b1}} >> (IN_W_L - len_eff));

  assign out_valid = (fill >= OUT_W_F) | ((state == S_FLUSH) & (fill != '0));
  assign out_data  = buf_q[OUT_WIDTH-1:0];
  assign out_last  = out_valid & (state == S_FLUSH) & (fill <= OUT_W_F);
  assign out_fire  = out_valid & out_ready;

  assign fill_base = out_fire ? ((fill >= OUT_W_F) ? fill - OUT_W_F : '0) : fill;
  assign in_ready  = (state == S_RUN) & (fill_base < OUT_W_F);
  assign in_fire   = in_valid & in_ready;

  assign busy       = (state == S_RUN) | (state == S_FLUSH);
  assign done       = (state == S_DONE);
  assign sess_clear = start & ((state == S_IDLE) | (state == S_DONE));

  assign buf_base = out_fire ? (buf_q >> OUT_WIDTH) : buf_q;
  assign buf_ins  = BUF_WIDTH'(in_masked) << fill_base;

  always_comb begin
    buf_nxt   = buf_base;
    fill_nxt  = fill_base;
    bits_nxt  = bits_in;
    words_nxt = words_out;
    if (in_fire) begin
      buf_nxt  = buf_base | buf_ins;
      fill_nxt = fill_base + FILL_WIDTH'(len_eff);
      bits_nxt = bits_in + 64'(len_eff);
    end
    if (out_fire) words_nxt = words_out + 32'd1;
    if (sess_clear) begin
      bits_nxt  = '0;
      words_nxt = '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (finish) state_nxt = S_FLUSH;
      S_FLUSH: if (fill_base == '0) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      buf_q     <= '0;
      fill      <= '0;
      bits_in   <= '0;
      words_out <= '0;
    end else begin
      state     <= state_nxt;
      buf_q     <= buf_nxt;
      fill      <= fill_nxt;
      bits_in   <= bits_nxt;
      words_out <= words_nxt;
    end
  end

  a_len_legal: assert property (@(posedge clk) disable iff (!rstn) in_fire |-> (in_len <= IN_W_L));

endmodule

// File: tb/tb_rr_trace_packer.sv
// Bench for rr_trace_packer: bit-queue reference model checked every cycle, a table of
// fill/backpressure steps, hand-written corner sequences and a randomized session.
module tb_rr_trace_packer;
  localparam int IW = 600;
  localparam int OW = 512;
  localparam int LW = $clog2(IW + 1);

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0, finish = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid, out_last, busy, done;
  logic [IW-1:0] in_data = '0;
  logic [LW-1:0] in_len = '0;
  logic [OW-1:0] out_data;
  logic [63:0]   bits_in;
  logic [31:0]   words_out;

  rr_trace_packer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_len(in_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .bits_in(bits_in), .words_out(words_out)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // reference model: every accepted bit in order, plus session flags
  bit     mq[$];
  logic   mon_en = 1'b0, in_sess = 1'b0, fin_sent = 1'b0, rand_rdy = 1'b0;
  longint exp_bits = 0;
  int     exp_words = 0, words_seen = 0, lasts_seen = 0, last_wait = 0;

  typedef struct {
    int     len;
    logic   ordy;
    longint bits;
    logic   ov;
    logic   ir;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_w(string nm, logic [OW-1:0] act, logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic          m_ov, m_ir, m_fire, m_last;
  int            m_base;
  logic [OW-1:0] m_word;

  always @(negedge clk) begin
    if (mon_en) begin
      m_ov = (mq.size() >= OW) || (fin_sent && mq.size() > 0);
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      m_fire = m_ov && out_ready;
      m_base = m_fire ? ((mq.size() >= OW) ? mq.size() - OW : 0) : mq.size();
      m_ir = in_sess && !fin_sent && (m_base < OW);
      chk("in_ready", 64'(in_ready), 64'(m_ir));
      if (out_valid && out_ready) begin
        for (int i = 0; i < OW; i++) m_word[i] = (mq.size() > 0) ? mq.pop_front() : 1'b0;
        m_last = fin_sent && (mq.size() == 0);
        exp_words++;
        words_seen++;
        if (out_last) lasts_seen++;
        chk_w("out_data", out_data, m_word);
        chk("out_last", 64'(out_last), 64'(m_last));
      end
      if (in_valid && in_ready) begin
        for (int i = 0; i < int'(in_len); i++) mq.push_back(in_data[i]);
        exp_bits += longint'(in_len);
      end
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic start_sess();
    start = 1'b1;
    sync();
    start = 1'b0;
    in_sess = 1'b1;
    fin_sent = 1'b0;
    mq.delete();
    exp_bits = 0;
    exp_words = 0;
    words_seen = 0;
    lasts_seen = 0;
  endtask

  task automatic finish_sess();
    finish = 1'b1;
    sync();
    finish = 1'b0;
    fin_sent = 1'b1;
  endtask

  // caller must be just after a rising edge
  task automatic send(int len, logic fin);
    int n = 0;
    in_valid = 1'b1;
    in_len = LW'(len);
    for (int k = 0; k < IW; k++) in_data[k] = 1'($urandom_range(0, 1));
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 300);
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got no in_ready after %0d cycles, required within 300", n);
    end
    if (fin) finish = 1'b1;
    sync();
    in_valid = 1'b0;
    in_len = '0;
    if (fin) begin
      finish = 1'b0;
      fin_sent = 1'b1;
    end
    last_wait = n;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("done", 64'(done), 64'd1);
    sync();
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required finish within 500000 time units");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{100, 1'b0, 100,  1'b0, 1'b1};
    tbl[1] = '{300, 1'b0, 400,  1'b0, 1'b1};
    tbl[2] = '{111, 1'b0, 511,  1'b0, 1'b1};
    tbl[3] = '{1,   1'b0, 512,  1'b1, 1'b0};
    tbl[4] = '{600, 1'b1, 1112, 1'b1, 1'b1};
    tbl[5] = '{0,   1'b0, 1112, 1'b0, 1'b1};
    tbl[6] = '{600, 1'b0, 1712, 1'b1, 1'b0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", {59'd0, out_valid, in_ready, out_last, busy, done}, 64'd0);
    chk("reset_bits_in", bits_in, 64'd0);
    chk("reset_words_out", 64'(words_out), 64'd0);
    rstn = 1'b1;
    sync();
    mon_en = 1'b1;
    chk("idle_flags", {59'd0, out_valid, in_ready, out_last, busy, done}, 64'd0);

    // four 200-bit units, finish afterwards
    out_ready = 1'b1;
    start_sess();
    chk("busy_run", 64'(busy), 64'd1);
    for (int u = 0; u < 4; u++) send(200, 1'b0);
    finish_sess();
    wait_done();
    chk("u200_bits_in", bits_in, 64'd800);
    chk("u200_words_out", 64'(words_out), 64'd2);
    chk("u200_words_seen", 64'(words_seen), 64'd2);
    chk("u200_lasts", 64'(lasts_seen), 64'd1);

    // eight full-width units stream one word per cycle
    start_sess();
    for (int u = 0; u < 8; u++) begin
      send(512, 1'b0);
      chk("burst_accept_wait", 64'(last_wait), 64'd1);
    end
    finish_sess();
    wait_done();
    chk("burst_words_out", 64'(words_out), 64'd8);
    chk("burst_lasts", 64'(lasts_seen), 64'd0);

    // table: fill boundary and backpressure steps
    start_sess();
    for (int i = 0; i < 7; i++) begin
      out_ready = tbl[i].ordy;
      send(tbl[i].len, 1'b0);
      @(negedge clk);
      chk("tbl_bits_in", bits_in, 64'(tbl[i].bits));
      chk("tbl_out_valid", 64'(out_valid), 64'(tbl[i].ov));
      chk("tbl_in_ready", 64'(in_ready), 64'(tbl[i].ir));
      sync();
    end
    out_ready = 1'b1;
    finish_sess();
    wait_done();
    chk("tbl_words_out", 64'(words_out), 64'(exp_words));

    // stall with fill at 600, then release
    out_ready = 1'b0;
    start_sess();
    send(600, 1'b0);
    @(negedge clk);
    m_word = out_data;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk_w("stall_out_data", out_data, m_word);
    end
    out_ready = 1'b1;
    sync();
    send(37, 1'b0);
    send(450, 1'b0);
    finish_sess();
    wait_done();
    chk("stall_bits_in", bits_in, 64'd1087);
    chk("stall_words_out", 64'(words_out), 64'd3);

    // two full words with finish on the second accept: no padded word
    start_sess();
    send(512, 1'b0);
    send(512, 1'b1);
    wait_done();
    chk("two_words_seen", 64'(words_seen), 64'd2);
    chk("two_lasts", 64'(lasts_seen), 64'd1);
    chk("two_words_out", 64'(words_out), 64'd2);

    // finish with empty buffer
    start_sess();
    finish_sess();
    wait_done();
    chk("empty_words_seen", 64'(words_seen), 64'd0);
    chk("empty_words_out", 64'(words_out), 64'd0);

    // len 0 / 600 interleaved, finish with the last accept
    start_sess();
    for (int u = 0; u < 6; u++) send((u % 2 == 0) ? 0 : 600, (u == 5));
    wait_done();
    chk("mix_bits_in", bits_in, 64'd1800);
    chk("mix_words_out", 64'(words_out), 64'd4);
    chk("mix_lasts", 64'(lasts_seen), 64'd1);

    // randomized lengths and backpressure
    start_sess();
    rand_rdy = 1'b1;
    for (int u = 0; u < 40; u++) begin
      int len;
      case ($urandom_range(0, 3))
        0:       len = 0;
        1:       len = IW;
        default: len = int'($urandom_range(1, IW - 1));
      endcase
      send(len, (u == 39));
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    wait_done();
    chk("rand_bits_in", bits_in, 64'(exp_bits));
    chk("rand_words_out", 64'(words_out), 64'(exp_words));
    chk("rand_lasts", 64'(lasts_seen), 64'(exp_bits > 0 ? 1 : 0));

    // reset mid-flush with a word pending
    out_ready = 1'b0;
    start_sess();
    send(600, 1'b0);
    finish_sess();
    @(negedge clk);
    chk("flush_pending_valid", 64'(out_valid), 64'd1);
    mon_en = 1'b0;
    rstn = 1'b0;
    #1;
    chk("rst_flags", {59'd0, out_valid, in_ready, out_last, busy, done}, 64'd0);
    chk("rst_counters", bits_in | 64'(words_out), 64'd0);
    mq.delete();
    in_sess = 1'b0;
    fin_sent = 1'b0;
    sync();
    rstn = 1'b1;
    mon_en = 1'b1;
    sync();
    start_sess();
    @(negedge clk);
    chk("restart_bits_in", bits_in, 64'd0);
    chk("restart_words_out", 64'(words_out), 64'd0);
    chk("restart_busy", 64'(busy), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
